// File: rtl/sm_accum_seq.sv
// Accumulating sequencer for the registered sign-magnitude addition ROM.
// Each operand is summed by looking up {acc, operand} in the ROM and capturing its output.
module sm_accum_seq #(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [7:0]  acc,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccept = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;

    localparam logic [2:0] LatLoad = 3'(ROM_LAT);

    logic [1:0]  r_state;
    logic [7:0]  r_acc;
    logic [15:0] r_addr;
    logic [7:0]  r_rem;
    logic [2:0]  r_wait;
    logic        r_done;

    logic [1:0]  w_state;
    logic [7:0]  w_acc;
    logic [15:0] w_addr;
    logic [7:0]  w_rem;
    logic [2:0]  w_wait;
    logic        w_done;

    always_comb begin
        w_state = r_state;
        w_acc   = r_acc;
        w_addr  = r_addr;
        w_rem   = r_rem;
        w_wait  = r_wait;
        w_done  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_acc = 8'h00;
                    w_rem = len;
                    if (len == 8'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state = StAccept;
                    end
                end
            end
            StAccept: begin
                if (in_valid) begin
                    w_addr  = {r_acc, in_data};
                    w_wait  = LatLoad;
                    w_state = StWait;
                end
            end
            StWait: begin
                // The counter reaching zero marks the edge where rom_data holds this step's sum.
                if (r_wait == 3'd0) begin
                    w_acc = rom_data;
                    w_rem = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_state = StIdle;
                        w_done  = 1'b1;
                    end else begin
                        w_state = StAccept;
                    end
                end else begin
                    w_wait = r_wait - 3'd1;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_acc   <= 8'h00;
            r_addr  <= 16'h0000;
            r_rem   <= 8'd0;
            r_wait  <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_acc   <= w_acc;
            r_addr  <= w_addr;
            r_rem   <= w_rem;
            r_wait  <= w_wait;
            r_done  <= w_done;
        end
    end

    assign in_ready = (r_state == StAccept);
    assign busy     = (r_state != StIdle);
    assign done     = r_done;
    assign acc      = r_acc;
    assign rom_addr = r_addr;

endmodule

// File: tb/tb_sm_accum_seq.sv
// Directed bench for sm_accum_seq with behavioural sign-magnitude ROMs at latencies 1 and 3.
module tb_sm_accum_seq;

    logic        clk;
    logic        reset_n;

    logic        start1, in_valid1, in_ready1, busy1, done1;
    logic [7:0]  len1, in_data1, rom_data1, acc1;
    logic [15:0] rom_addr1;

    logic        start3, in_valid3, in_ready3, busy3, done3;
    logic [7:0]  len3, in_data3, rom_data3, acc3;
    logic [15:0] rom_addr3;

    int total;
    int bad;

    sm_accum_seq #(.ROM_LAT(1)) u_dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start1),
        .len      (len1),
        .in_data  (in_data1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .rom_addr (rom_addr1),
        .rom_data (rom_data1),
        .acc      (acc1),
        .busy     (busy1),
        .done     (done1)
    );

    sm_accum_seq #(.ROM_LAT(3)) u_dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start3),
        .len      (len3),
        .in_data  (in_data3),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .rom_addr (rom_addr3),
        .rom_data (rom_data3),
        .acc      (acc3),
        .busy     (busy3),
        .done     (done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] sm_add(input logic [15:0] a);
        logic       sa, sb;
        logic [6:0] ma, mb;
        sa = a[15];
        ma = a[14:8];
        sb = a[7];
        mb = a[6:0];
        if (sa == sb) return {sa, 7'(ma + mb)};
        else if (ma >= mb) return {sa, 7'(ma - mb)};
        else return {sb, 7'(mb - ma)};
    endfunction

    // ROM models: data for an address appears ROM_LAT edges after the address changes.
    logic [7:0] p3_0, p3_1;
    always @(posedge clk) begin
        rom_data1 <= sm_add(rom_addr1);
        p3_0      <= sm_add(rom_addr3);
        p3_1      <= p3_0;
        rom_data3 <= p3_1;
    end

    typedef struct {
        logic [7:0]       len;
        logic [2:0][7:0]  ops;
        logic [2:0][15:0] addrs;
        logic [2:0][7:0]  accs;
    } vec_t;

    vec_t vecs[4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_ready1();
        int n;
        n = 0;
        while (in_ready1 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (in_ready1 !== 1'b1) chk("in_ready1_timeout", {15'd0, in_ready1}, 16'd1);
    endtask

    task automatic wait_ready3();
        int n;
        n = 0;
        while (in_ready3 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (in_ready3 !== 1'b1) chk("in_ready3_timeout", {15'd0, in_ready3}, 16'd1);
    endtask

    task automatic run_vec(input int k);
        vec_t       v;
        logic [7:0] prev;
        v = vecs[k];
        start1 = 1'b1;
        len1   = v.len;
        step();
        start1 = 1'b0;
        chk("start_busy", {15'd0, busy1}, 16'd1);
        chk("start_ready", {15'd0, in_ready1}, 16'd1);
        chk("start_acc", {8'd0, acc1}, 16'h0000);
        for (int i = 0; i < int'(v.len); i++) begin
            in_data1  = v.ops[i];
            in_valid1 = 1'b1;
            wait_ready1();
            step();
            in_valid1 = 1'b0;
            in_data1  = 8'h55;
            chk($sformatf("v%0d_addr%0d", k, i), rom_addr1, v.addrs[i]);
            chk($sformatf("v%0d_ready_wait%0d", k, i), {15'd0, in_ready1}, 16'd0);
            prev = (i == 0) ? 8'h00 : v.accs[i-1];
            step();
            chk($sformatf("v%0d_acc_hold%0d", k, i), {8'd0, acc1}, {8'd0, prev});
            step();
            chk($sformatf("v%0d_acc%0d", k, i), {8'd0, acc1}, {8'd0, v.accs[i]});
            if (i == int'(v.len) - 1) begin
                chk($sformatf("v%0d_done", k), {15'd0, done1}, 16'd1);
                chk($sformatf("v%0d_busy_drop", k), {15'd0, busy1}, 16'd0);
                step();
                chk($sformatf("v%0d_done_pulse", k), {15'd0, done1}, 16'd0);
                chk($sformatf("v%0d_acc_held", k), {8'd0, acc1}, {8'd0, v.accs[i]});
            end else begin
                chk($sformatf("v%0d_ready_again%0d", k, i), {15'd0, in_ready1}, 16'd1);
                chk($sformatf("v%0d_no_done%0d", k, i), {15'd0, done1}, 16'd0);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        start1 = 1'b0; len1 = 8'd0; in_data1 = 8'd0; in_valid1 = 1'b0;
        start3 = 1'b0; len3 = 8'd0; in_data3 = 8'd0; in_valid3 = 1'b0;

        vecs[0].len = 8'd3;
        vecs[0].ops = {8'h0A, 8'h83, 8'h05};
        vecs[0].addrs = {16'h020A, 16'h0583, 16'h0005};
        vecs[0].accs = {8'h0C, 8'h02, 8'h05};
        vecs[1].len = 8'd2;
        vecs[1].ops = {8'h00, 8'h81, 8'h81};
        vecs[1].addrs = {16'h0000, 16'h8181, 16'h0081};
        vecs[1].accs = {8'h00, 8'h82, 8'h81};
        vecs[2].len = 8'd3;
        vecs[2].ops = {8'h80, 8'h05, 8'h85};
        vecs[2].addrs = {16'h8080, 16'h8505, 16'h0085};
        vecs[2].accs = {8'h80, 8'h80, 8'h85};
        vecs[3].len = 8'd1;
        vecs[3].ops = {8'h00, 8'h00, 8'h7F};
        vecs[3].addrs = {16'h0000, 16'h0000, 16'h007F};
        vecs[3].accs = {8'h00, 8'h00, 8'h7F};

        step();
        step();
        chk("rst_acc", {8'd0, acc1}, 16'h0000);
        chk("rst_addr", rom_addr1, 16'h0000);
        chk("rst_ready", {15'd0, in_ready1}, 16'd0);
        chk("rst_busy", {15'd0, busy1}, 16'd0);
        chk("rst_done", {15'd0, done1}, 16'd0);
        reset_n = 1'b1;
        step();
        chk("idle_busy", {15'd0, busy1}, 16'd0);
        chk("idle_ready", {15'd0, in_ready1}, 16'd0);

        for (int k = 0; k < 4; k++) run_vec(k);

        // Zero-length sequence; acc still holds 0x7F from the previous run.
        start1 = 1'b1;
        len1   = 8'd0;
        step();
        start1 = 1'b0;
        chk("z_done", {15'd0, done1}, 16'd1);
        chk("z_acc", {8'd0, acc1}, 16'h0000);
        chk("z_busy", {15'd0, busy1}, 16'd0);
        chk("z_ready", {15'd0, in_ready1}, 16'd0);
        step();
        chk("z_done_pulse", {15'd0, done1}, 16'd0);
        chk("z_busy2", {15'd0, busy1}, 16'd0);

        // Backpressure, then a start pulse while busy.
        start1 = 1'b1;
        len1   = 8'd2;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_ready%0d", i), {15'd0, in_ready1}, 16'd1);
            chk($sformatf("bp_acc%0d", i), {8'd0, acc1}, 16'h0000);
        end
        in_data1  = 8'h03;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        step();
        chk("bp_acc_a", {8'd0, acc1}, 16'h0003);
        start1 = 1'b1;
        len1   = 8'd9;
        step();
        start1 = 1'b0;
        chk("bp_start_acc", {8'd0, acc1}, 16'h0003);
        chk("bp_start_ready", {15'd0, in_ready1}, 16'd1);
        chk("bp_start_busy", {15'd0, busy1}, 16'd1);
        in_data1  = 8'h04;
        in_valid1 = 1'b1;
        wait_ready1();
        step();
        in_valid1 = 1'b0;
        chk("bp_addr_b", rom_addr1, 16'h0304);
        step();
        step();
        chk("bp_acc_b", {8'd0, acc1}, 16'h0007);
        chk("bp_done", {15'd0, done1}, 16'd1);
        chk("bp_busy", {15'd0, busy1}, 16'd0);
        step();

        // Reset lands on the edge that would have finished the sequence.
        start1 = 1'b1;
        len1   = 8'd2;
        step();
        start1 = 1'b0;
        in_data1  = 8'h05;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        step();
        in_data1  = 8'h06;
        in_valid1 = 1'b1;
        wait_ready1();
        step();
        in_valid1 = 1'b0;
        chk("mr_addr", rom_addr1, 16'h0506);
        step();
        reset_n = 1'b0;
        step();
        chk("mr_acc", {8'd0, acc1}, 16'h0000);
        chk("mr_addr0", rom_addr1, 16'h0000);
        chk("mr_ready", {15'd0, in_ready1}, 16'd0);
        chk("mr_busy", {15'd0, busy1}, 16'd0);
        chk("mr_done", {15'd0, done1}, 16'd0);
        step();
        chk("mr_done_b", {15'd0, done1}, 16'd0);
        reset_n = 1'b1;
        step();
        chk("mr_done_c", {15'd0, done1}, 16'd0);
        chk("mr_busy_c", {15'd0, busy1}, 16'd0);
        step();
        chk("mr_done_d", {15'd0, done1}, 16'd0);

        // ROM_LAT=3 instance: acc updates 4 edges after each handshake.
        start3 = 1'b1;
        len3   = 8'd3;
        step();
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data3  = vecs[0].ops[i];
            in_valid3 = 1'b1;
            wait_ready3();
            step();
            in_valid3 = 1'b0;
            chk($sformatf("l3_addr%0d", i), rom_addr3, vecs[0].addrs[i]);
            step();
            step();
            step();
            chk($sformatf("l3_hold%0d", i), {8'd0, acc3},
                {8'd0, (i == 0) ? 8'h00 : vecs[0].accs[i-1]});
            chk($sformatf("l3_ready_wait%0d", i), {15'd0, in_ready3}, 16'd0);
            step();
            chk($sformatf("l3_acc%0d", i), {8'd0, acc3}, {8'd0, vecs[0].accs[i]});
        end
        chk("l3_done", {15'd0, done3}, 16'd1);
        chk("l3_busy", {15'd0, busy3}, 16'd0);
        step();
        chk("l3_done_pulse", {15'd0, done3}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
